snail_seq_det: RTL and testbench
================================

# snail_seq_det

Parametrised serial sequence detector, successor to the fixed 4-bit snail detector. It watches a one-bit stream qualified by a valid strobe and raises a same-cycle (Mealy) `smile` pulse when the last PAT_W accepted bits equal a runtime-loadable pattern. The detection mode is selectable: overlapping matches, or matches that restart after each hit. It sits between the serial input synchroniser and the lab's status/LED logic, and optionally keeps a saturating match counter.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..32.
- RST_PAT, 4'b1001: pattern loaded at reset; PAT_W bits wide.
- CNT_W, 8: width of the match counter.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; one clock domain only.
- number  input  1  serial data bit.
- valid  input  1  `number` is accepted on this edge when high.
- load  input  1  loads `pattern` on this edge and restarts detection.
- pattern  input  PAT_W  new pattern; the MSB is the first bit received.
- overlap  input  1  1 = overlapping matches allowed; 0 = restart after a match.
- smile  output  1  combinational match pulse.
- match_count  output  CNT_W  saturating count of matches.

## Operation
- State:
  - pat_q[PAT_W-1:0]: the active pattern.
  - hist[PAT_W-2:0]: the last accepted bits; the newest bit is in the LSB.
  - fill: number of valid history bits, 0..PAT_W-1, saturating at PAT_W-1.
  - cnt[CNT_W-1:0].
- Match term: valid & ~load & (fill == PAT_W-1) & ({hist, number} == pat_q).
- smile equals the match term. It is a Mealy output, high in the same cycle as the completing bit.
- Accepted bit (valid=1, load=0), no match: hist <= {hist[PAT_W-3:0], number}; fill <= min(fill+1, PAT_W-1).
- Accepted bit with a match:
  - overlap=1: hist and fill update as in the no-match case, so trailing bits can begin the next match.
  - overlap=0: hist <= 0 and fill <= 0.
- valid=0: hist and fill hold, and smile=0.
- load=1 takes priority over valid. pat_q <= pattern; hist, fill and cnt clear; `number` is ignored; smile=0.
- `overlap` is sampled on each match cycle and may change freely between matches.
- Counter arithmetic: cnt is unsigned. It increments on every smile cycle and holds at 2^CNT_W-1; it never wraps.

## Timing
- Reset values: pat_q=RST_PAT, hist=0, fill=0, cnt=0. smile=0 during and after reset until PAT_W bits have been accepted. match_count=0.
- Latency: smile has 0 cycles of latency from `number`/valid. match_count reflects a match on the rising edge after the smile cycle.
- Reset mid-stream discards any partial match immediately, asynchronously. The first possible smile is on the PAT_W-th accepted bit after reset release.
- A load edge costs one cycle. The first possible smile after load is on the PAT_W-th accepted bit after the load cycle.

## Configuration
- SNAIL_MATCH_CNT_EN:
  - Defined: cnt and its saturation logic are built, and match_count is driven as specified.
  - Undefined: no counter flops are built, and match_count is tied to 0.
  - The port list is identical in both builds.

## Structure
- Shared package snail_pkg holds:
  - default constants PAT_W_DEF=4, CNT_W_DEF=8, RST_PAT_DEF=4'b1001;
  - mode constants MODE_RESTART=1'b0, MODE_OVERLAP=1'b1.
- Sub-module snail_hist holds the history shift register and saturating fill counter, with clear/shift controls. The top level keeps pat_q, the compare, smile and the counter.

## Test plan
All scenarios use PAT_W=4 and RST_PAT=1001 unless stated.
- Basic match: after reset, send 1,0,0,1 with valid=1 every cycle. smile=1 only in the 4th cycle; match_count=1 after the next edge.
- Overlap mode:
  - overlap=1, stream 1,0,0,1,0,0,1: smile on bits 4 and 7; match_count=2.
  - overlap=0, same stream: smile on bit 4 only; match_count=1.
- Valid bubbles: send 1,(valid=0),0,0,(valid=0),1. smile=1 only on the final valid bit and is never high in a bubble cycle.
- Reload: send 1,0, then load with pattern=0110, then 0,1,1,0.
  - smile=0 in the load cycle.
  - smile=1 on the final 0; match_count=1, reflecting the clear on load.
  - Apply load and valid with number=1 together: the bit is ignored.
- Saturation: with CNT_W=2, produce 5 matches. match_count reads 1,2,3,3,3.
- Reset mid-stream: send 1,0,0, pulse reset asynchronously between edges, then send 1. smile=0 and match_count=0. Repeat the test with SNAIL_MATCH_CNT_EN undefined: match_count stays 0 throughout.

Source files
------------

// File: rtl/snail_pkg.sv
// Shared constants for the snail sequence detector family.
package snail_pkg;

   localparam int unsigned PAT_W_DEF   = 4;
   localparam int unsigned CNT_W_DEF   = 8;
   localparam logic [3:0]  RST_PAT_DEF = 4'b1001;

   // Values of the overlap input
   localparam logic MODE_RESTART = 1'b0;
   localparam logic MODE_OVERLAP = 1'b1;

endpackage

// File: rtl/snail_hist.sv
// History shift register plus saturating fill counter for the sequence detector.
// clear_i has priority over shift_i.
module snail_hist
   import snail_pkg::*;
#(
   parameter int unsigned PAT_W = PAT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             shift_i,
   input  logic             bit_i,
   output logic [PAT_W-2:0] hist_o,
   output logic             full_o
);

   // Fill only has to reach PAT_W-1
   localparam int unsigned FillW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
   localparam logic [FillW-1:0] FillMax = FillW'(PAT_W - 1);

   logic [PAT_W-2:0] hist_d, hist_q;
   logic [FillW-1:0] fill_d, fill_q;
   logic [PAT_W-1:0] shifted;

   assign shifted = {hist_q, bit_i};

   // Next-state: clear, shift in the newest bit at the LSB, or hold
   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      if (clear_i) begin
         hist_d = '0;
         fill_d = '0;
      end else if (shift_i) begin
         hist_d = shifted[PAT_W-2:0];
         if (fill_q != FillMax) begin
            fill_d = fill_q + 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

   assign hist_o = hist_q;
   assign full_o = (fill_q == FillMax);

endmodule

// File: rtl/snail_seq_det.sv
// Parametrised serial sequence detector with a Mealy match pulse and a loadable pattern.
// Optional saturating match counter is built when SNAIL_MATCH_CNT_EN is defined;
// otherwise match_count is tied to zero.
module snail_seq_det
   import snail_pkg::*;
#(
   parameter int unsigned     PAT_W   = PAT_W_DEF,
   parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(RST_PAT_DEF),
   parameter int unsigned     CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             number,
   input  logic             valid,
   input  logic             load,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   output logic             smile,
   output logic [CNT_W-1:0] match_count
);

   logic [PAT_W-1:0] pat_d, pat_q;
   logic [PAT_W-2:0] hist;
   logic             full;
   logic             accept;
   logic             hist_clear;

   // load wins over valid, so a bit presented with load is dropped
   assign accept     = valid & ~load;
   assign smile      = accept & full & ({hist, number} == pat_q);
   assign hist_clear = load | (smile & (overlap == MODE_RESTART));

   snail_hist #(
      .PAT_W (PAT_W)
   ) u_hist (
      .clk     (clk),
      .reset   (reset),
      .clear_i (hist_clear),
      .shift_i (accept),
      .bit_i   (number),
      .hist_o  (hist),
      .full_o  (full)
   );

   // Pattern next-state
   always_comb begin
      pat_d = pat_q;
      if (load) begin
         pat_d = pattern;
      end
   end

   // Pattern register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q <= RST_PAT;
      end else begin
         pat_q <= pat_d;
      end
   end

`ifdef SNAIL_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_d, cnt_q;

   // Saturating counter next-state; cleared by load
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (smile && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_count = cnt_q;
`else
   assign match_count = '0;
`endif

endmodule

// File: tb/tb_snail_seq_det.sv
// Directed self-checking bench for snail_seq_det (PAT_W=4, RST_PAT=1001).
// Two instances share stimulus: CNT_W=8 and CNT_W=2 for saturation.
module tb_snail_seq_det;

`ifdef SNAIL_MATCH_CNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       number;
   logic       valid;
   logic       load;
   logic [3:0] pattern;
   logic       overlap;
   logic       smile, smile_s;
   logic [7:0] match_count;
   logic [1:0] match_count_s;

   int checks = 0;
   int errors = 0;
   int nmatch = 0;

   snail_seq_det #(
      .PAT_W   (4),
      .RST_PAT (4'b1001),
      .CNT_W   (8)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .number      (number),
      .valid       (valid),
      .load        (load),
      .pattern     (pattern),
      .overlap     (overlap),
      .smile       (smile),
      .match_count (match_count)
   );

   snail_seq_det #(
      .PAT_W   (4),
      .RST_PAT (4'b1001),
      .CNT_W   (2)
   ) u_sat (
      .clk         (clk),
      .reset       (reset),
      .number      (number),
      .valid       (valid),
      .load        (load),
      .pattern     (pattern),
      .overlap     (overlap),
      .smile       (smile_s),
      .match_count (match_count_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_cnt(input int n);
      return CntEn ? 32'(n) : 32'd0;
   endfunction

   function automatic logic [31:0] exp_sat(input int n);
      return CntEn ? ((n > 3) ? 32'd3 : 32'(n)) : 32'd0;
   endfunction

   task automatic check_cnt(input string tag, input int n);
      check({tag, "_cnt"}, 32'(match_count), exp_cnt(n));
      check({tag, "_sat"}, 32'(match_count_s), exp_sat(n));
   endtask

   // Drive one cycle at the negedge, check smile mid-cycle, return inputs to idle after the edge
   task automatic step(input string tag, input logic b, input logic v, input logic exp_smile);
      @(negedge clk);
      number = b;
      valid  = v;
      load   = 1'b0;
      #1;
      check(tag, 32'(smile), 32'(exp_smile));
      check({tag, "_s"}, 32'(smile_s), 32'(exp_smile));
      @(posedge clk);
      #1;
      valid  = 1'b0;
      number = 1'b0;
   endtask

   task automatic load_step(input string tag, input logic [3:0] p, input logic b, input logic v);
      @(negedge clk);
      pattern = p;
      load    = 1'b1;
      number  = b;
      valid   = v;
      #1;
      check(tag, 32'(smile), 32'd0);
      @(posedge clk);
      #1;
      load   = 1'b0;
      valid  = 1'b0;
      number = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      number  = 1'b0;
      valid   = 1'b0;
      load    = 1'b0;
      pattern = 4'b0000;
      overlap = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_smile", 32'(smile), 32'd0);
      check_cnt("rst", 0);
      @(negedge clk);
      reset = 1'b0;

      // Basic match with overlap, then trailing bits complete a second match
      step("basic_b1", 1'b1, 1'b1, 1'b0);
      step("basic_b2", 1'b0, 1'b1, 1'b0);
      step("basic_b3", 1'b0, 1'b1, 1'b0);
      step("basic_b4", 1'b1, 1'b1, 1'b1);
      check_cnt("basic", 1);
      step("ovl_b5", 1'b0, 1'b1, 1'b0);
      step("ovl_b6", 1'b0, 1'b1, 1'b0);
      step("ovl_b7", 1'b1, 1'b1, 1'b1);
      check_cnt("ovl", 2);

      // Restart mode: the shared 1 cannot start a new match
      load_step("rs_load", 4'b1001, 1'b0, 1'b0);
      check_cnt("rs_load", 0);
      overlap = 1'b0;
      step("rs_b1", 1'b1, 1'b1, 1'b0);
      step("rs_b2", 1'b0, 1'b1, 1'b0);
      step("rs_b3", 1'b0, 1'b1, 1'b0);
      step("rs_b4", 1'b1, 1'b1, 1'b1);
      step("rs_b5", 1'b0, 1'b1, 1'b0);
      step("rs_b6", 1'b0, 1'b1, 1'b0);
      step("rs_b7", 1'b1, 1'b1, 1'b0);
      check_cnt("rs", 1);
      overlap = 1'b1;

      // Valid bubbles: the second bubble carries the completing bit value but must not match
      load_step("bub_load", 4'b1001, 1'b0, 1'b0);
      step("bub_b1", 1'b1, 1'b1, 1'b0);
      step("bub_x1", 1'b1, 1'b0, 1'b0);
      step("bub_b2", 1'b0, 1'b1, 1'b0);
      step("bub_b3", 1'b0, 1'b1, 1'b0);
      step("bub_x2", 1'b1, 1'b0, 1'b0);
      step("bub_b4", 1'b1, 1'b1, 1'b1);
      check_cnt("bub", 1);

      // Reload mid-stream: partial history and count are discarded
      step("rl_b1", 1'b1, 1'b1, 1'b0);
      step("rl_b2", 1'b0, 1'b1, 1'b0);
      load_step("rl_load", 4'b0110, 1'b0, 1'b0);
      check_cnt("rl_load", 0);
      step("rl_c1", 1'b0, 1'b1, 1'b0);
      step("rl_c2", 1'b1, 1'b1, 1'b0);
      step("rl_c3", 1'b1, 1'b1, 1'b0);
      step("rl_c4", 1'b0, 1'b1, 1'b1);
      check_cnt("rl", 1);

      // Load together with valid: the bit must be dropped, so 1,1,0 alone cannot match 1110
      load_step("lv_load", 4'b1110, 1'b1, 1'b1);
      step("lv_b1", 1'b1, 1'b1, 1'b0);
      step("lv_b2", 1'b1, 1'b1, 1'b0);
      step("lv_b3", 1'b0, 1'b1, 1'b0);
      check_cnt("lv", 0);

      // Saturation: five overlapping matches, 2-bit counter sticks at 3
      load_step("sat_load", 4'b1001, 1'b0, 1'b0);
      nmatch = 0;
      for (int i = 0; i < 16; i++) begin
         logic b;
         logic e;
         b = (i % 3 == 0);
         e = (i >= 3) && (i % 3 == 0);
         step($sformatf("sat_b%0d", i), b, 1'b1, e);
         if (e) begin
            nmatch++;
            check_cnt($sformatf("sat_m%0d", nmatch), nmatch);
         end
      end

      // Asynchronous reset mid-stream discards the partial 1,0,0
      step("mr_b1", 1'b1, 1'b1, 1'b0);
      step("mr_b2", 1'b0, 1'b1, 1'b0);
      step("mr_b3", 1'b0, 1'b1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check_cnt("mr_async", 0);
      #1;
      reset = 1'b0;
      step("mr_b4", 1'b1, 1'b1, 1'b0);
      check_cnt("mr", 0);
      step("mr_c2", 1'b0, 1'b1, 1'b0);
      step("mr_c3", 1'b0, 1'b1, 1'b0);
      step("mr_c4", 1'b1, 1'b1, 1'b1);
      check_cnt("mr_after", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
